// File: rtl/gpio_emu.sv
// Memory-mapped GPIO emulator: operand/product registers around a 24x24 shift-add
// multiplier, a completion counter mirrored on gpio_out, and a GPIO input snapshot.
module gpio_emu (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   input  logic [31:0] gpio_in,
   input  logic        gpio_latch,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_in_s_insp
);

   localparam logic [15:0] ADDR_A1  = 16'h0430;
   localparam logic [15:0] ADDR_A2  = 16'h0438;
   localparam logic [15:0] ADDR_WL  = 16'h0440;
   localparam logic [15:0] ADDR_WH  = 16'h0448;
   localparam logic [15:0] ADDR_B   = 16'h0450;
   localparam logic [15:0] ADDR_CNT = 16'h0458;

   logic        srd_reg, swr_reg, latch_reg;
   logic [23:0] a1_reg, a2_reg;
   logic [23:0] mplier_reg;
   logic [47:0] mcand_reg, acc_reg, prod_reg;
   logic [4:0]  iter_reg;
   logic        busy_reg, done_reg;
   logic [31:0] cnt_reg;

   logic        rd_edge, wr_edge, latch_edge;
   logic [47:0] acc_next;
   logic [31:0] rd_data;
   logic        unused_bits;

   assign rd_edge     = srd & ~srd_reg;
   assign wr_edge     = swr & ~swr_reg;
   assign latch_edge  = gpio_latch & ~latch_reg;
   assign gpio_out    = cnt_reg;
   assign unused_bits = ^sdata_in[31:24];

   // One multiplier bit per cycle, LSB first; multiplicand shifts left alongside.
   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   always_comb begin
      rd_data = 32'h0;
      case (saddress)
         ADDR_A1:  rd_data = {8'h0, a1_reg};
         ADDR_A2:  rd_data = {8'h0, a2_reg};
         ADDR_WL:  rd_data = prod_reg[31:0];
         ADDR_WH:  rd_data = {16'h0, prod_reg[47:32]};
         ADDR_B:   rd_data = {30'h0, done_reg, busy_reg};
         ADDR_CNT: rd_data = cnt_reg;
         default:  rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_reset) begin
         srd_reg        <= 1'b0;
         swr_reg        <= 1'b0;
         latch_reg      <= 1'b0;
         a1_reg         <= '0;
         a2_reg         <= '0;
         mplier_reg     <= '0;
         mcand_reg      <= '0;
         acc_reg        <= '0;
         prod_reg       <= '0;
         iter_reg       <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         cnt_reg        <= '0;
         sdata_out      <= '0;
         gpio_in_s_insp <= '0;
      end else begin
         srd_reg   <= srd;
         swr_reg   <= swr;
         latch_reg <= gpio_latch;

         if (latch_edge)
            gpio_in_s_insp <= gpio_in;

         // A simultaneous write edge wins; the read is dropped and sdata_out holds.
         if (rd_edge && !wr_edge)
            sdata_out <= rd_data;

         if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[46:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[23:1]};
            iter_reg   <= iter_reg + 5'd1;
            if (iter_reg == 5'd23) begin
               prod_reg <= acc_next;
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
               cnt_reg  <= cnt_reg + 32'd1;
            end
         end else if (wr_edge) begin
            case (saddress)
               ADDR_A1: a1_reg <= sdata_in[23:0];
               ADDR_A2: begin
                  a2_reg     <= sdata_in[23:0];
                  mplier_reg <= sdata_in[23:0];
                  mcand_reg  <= {24'h0, a1_reg};
                  acc_reg    <= '0;
                  iter_reg   <= '0;
                  busy_reg   <= 1'b1;
                  done_reg   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpio_emu.sv
// Directed bench for gpio_emu: register access, multiply latency/results,
// strobe edge handling, GPIO snapshot and reset abort.
module tb_gpio_emu;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] saddress;
   logic        srd, swr;
   logic [31:0] sdata_in;
   logic [31:0] sdata_out;
   logic [31:0] gpio_in;
   logic        gpio_latch;
   logic [31:0] gpio_out;
   logic [31:0] gpio_in_s_insp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gpio_emu dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .saddress       (saddress),
      .srd            (srd),
      .swr            (swr),
      .sdata_in       (sdata_in),
      .sdata_out      (sdata_out),
      .gpio_in        (gpio_in),
      .gpio_latch     (gpio_latch),
      .gpio_out       (gpio_out),
      .gpio_in_s_insp (gpio_in_s_insp)
   );

   task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      saddress = addr; sdata_in = data; swr = 1'b1;
      @(posedge clk); #1;
      swr = 1'b0;
      $display("[%0t] wr addr=0x%04h data=0x%08h", $time, addr, data);
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
      @(posedge clk); #1;
      saddress = addr; srd = 1'b1;
      @(posedge clk); #1;
      srd = 1'b0;
      data = sdata_out;
      $display("[%0t] rd addr=0x%04h data=0x%08h", $time, addr, data);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic [15:0] addrs [6];
      addrs = '{16'h0430, 16'h0438, 16'h0440, 16'h0448, 16'h0450, 16'h0458};
      n_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 n_reset = 1'b0;
      n_checks++;
      if (sdata_out !== 32'h0 || gpio_out !== 32'h0 || gpio_in_s_insp !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: sdata_out=0x%08h gpio_out=0x%08h insp=0x%08h, expected all 0",
                  sdata_out, gpio_out, gpio_in_s_insp);
      end
      for (int i = 0; i < 6; i++) begin
         bus_read(addrs[i], d);
         n_checks++;
         if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read_%04h: got 0x%08h expected 0x00000000", addrs[i], d);
         end
      end
   endtask

   task automatic test_a1_access;
      logic [31:0] d;
      bus_write(16'h0430, 32'h0000_2137);
      bus_read(16'h0430, d);
      n_checks++;
      if (d !== 32'h0000_2137) begin
         n_fail++;
         $display("FAIL a1_rw: got 0x%08h expected 0x00002137", d);
      end
      bus_write(16'h0430, 32'hAB12_3456);
      bus_read(16'h0430, d);
      n_checks++;
      if (d !== 32'h0012_3456) begin
         n_fail++;
         $display("FAIL a1_truncate: got 0x%08h expected 0x00123456", d);
      end
   endtask

   task automatic test_multiply;
      logic [31:0] d;
      bus_write(16'h0430, 32'h0000_2137);
      bus_write(16'h0438, 32'h0000_0125);
      // Now 1 ns after the start edge: the counter must move exactly 24 edges later.
      repeat (23) @(posedge clk);
      #1;
      n_checks++;
      if (gpio_out !== 32'd0) begin
         n_fail++;
         $display("FAIL mul_latency_early: gpio_out=%0d expected 0 after 23 clks", gpio_out);
      end
      @(posedge clk); #1;
      n_checks++;
      if (gpio_out !== 32'd1) begin
         n_fail++;
         $display("FAIL mul_latency_done: gpio_out=%0d expected 1 after 24 clks", gpio_out);
      end
      bus_read(16'h0450, d);
      n_checks++;
      if (d !== 32'h2) begin
         n_fail++;
         $display("FAIL mul_status_done: got 0x%08h expected 0x00000002", d);
      end
      bus_read(16'h0440, d);
      n_checks++;
      if (d !== 32'h0026_03F3) begin
         n_fail++;
         $display("FAIL mul_wl: got 0x%08h expected 0x002603F3", d);
      end
      bus_read(16'h0448, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL mul_wh: got 0x%08h expected 0x00000000", d);
      end
      bus_read(16'h0458, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++;
         $display("FAIL mul_cnt: got 0x%08h expected 0x00000001", d);
      end
   endtask

   task automatic test_max_and_busy;
      logic [31:0] d;
      bus_write(16'h0430, 32'h00FF_FFFF);
      bus_write(16'h0438, 32'h00FF_FFFF);
      bus_read(16'h0450, d);
      n_checks++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL busy_status: got 0x%08h expected 0x00000001", d);
      end
      bus_read(16'h0440, d);
      n_checks++;
      if (d !== 32'h0026_03F3) begin
         n_fail++;
         $display("FAIL busy_wl_holds: got 0x%08h expected 0x002603F3", d);
      end
      bus_write(16'h0438, 32'h0000_0005);
      bus_write(16'h0430, 32'h0000_0007);
      repeat (30) @(posedge clk);
      bus_read(16'h0440, d);
      n_checks++;
      if (d !== 32'hFE00_0001) begin
         n_fail++;
         $display("FAIL max_wl: got 0x%08h expected 0xFE000001", d);
      end
      bus_read(16'h0448, d);
      n_checks++;
      if (d !== 32'h0000_FFFF) begin
         n_fail++;
         $display("FAIL max_wh: got 0x%08h expected 0x0000FFFF", d);
      end
      bus_read(16'h0458, d);
      n_checks++;
      if (d !== 32'd2) begin
         n_fail++;
         $display("FAIL busy_write_cnt: got 0x%08h expected 0x00000002", d);
      end
      bus_read(16'h0430, d);
      n_checks++;
      if (d !== 32'h00FF_FFFF) begin
         n_fail++;
         $display("FAIL busy_a1_ignored: got 0x%08h expected 0x00FFFFFF", d);
      end
      bus_read(16'h0438, d);
      n_checks++;
      if (d !== 32'h00FF_FFFF) begin
         n_fail++;
         $display("FAIL busy_a2_ignored: got 0x%08h expected 0x00FFFFFF", d);
      end
   endtask

   task automatic test_readonly_and_long_strobe;
      logic [31:0] d;
      bus_write(16'h0440, 32'hFFFF_FFFF);
      bus_write(16'h0448, 32'hFFFF_FFFF);
      bus_write(16'h0450, 32'hFFFF_FFFF);
      bus_write(16'h0460, 32'hFFFF_FFFF);
      bus_read(16'h0440, d);
      n_checks++;
      if (d !== 32'hFE00_0001) begin
         n_fail++;
         $display("FAIL ro_wl: got 0x%08h expected 0xFE000001", d);
      end
      bus_read(16'h0450, d);
      n_checks++;
      if (d !== 32'h2) begin
         n_fail++;
         $display("FAIL ro_status: got 0x%08h expected 0x00000002", d);
      end
      bus_read(16'h0458, d);
      n_checks++;
      if (d !== 32'd2) begin
         n_fail++;
         $display("FAIL ro_cnt: got 0x%08h expected 0x00000002", d);
      end
      bus_read(16'h0460, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL unmapped_read: got 0x%08h expected 0x00000000", d);
      end
      bus_write(16'h0430, 32'h0000_0002);
      @(posedge clk); #1;
      saddress = 16'h0438; sdata_in = 32'h3; swr = 1'b1;
      repeat (3) @(posedge clk);
      #1 swr = 1'b0;
      $display("[%0t] wr addr=0x0438 data=0x00000003 (3-cycle strobe)", $time);
      repeat (30) @(posedge clk);
      bus_read(16'h0458, d);
      n_checks++;
      if (d !== 32'd3) begin
         n_fail++;
         $display("FAIL pulse3_cnt: got 0x%08h expected 0x00000003", d);
      end
      bus_read(16'h0440, d);
      n_checks++;
      if (d !== 32'h6) begin
         n_fail++;
         $display("FAIL pulse3_wl: got 0x%08h expected 0x00000006", d);
      end
      // Strobe outlasting the whole multiply must still start only one operation.
      @(posedge clk); #1;
      saddress = 16'h0438; sdata_in = 32'h4; swr = 1'b1;
      repeat (40) @(posedge clk);
      #1 swr = 1'b0;
      $display("[%0t] wr addr=0x0438 data=0x00000004 (40-cycle strobe)", $time);
      repeat (30) @(posedge clk);
      #1;
      n_checks++;
      if (gpio_out !== 32'd4) begin
         n_fail++;
         $display("FAIL long_strobe_cnt: gpio_out=%0d expected 4", gpio_out);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      bus_read(16'h0430, d);
      @(posedge clk); #1;
      saddress = 16'h0430; sdata_in = 32'h55; srd = 1'b1; swr = 1'b1;
      @(posedge clk); #1;
      srd = 1'b0; swr = 1'b0;
      $display("[%0t] rd+wr addr=0x0430 data=0x00000055", $time);
      n_checks++;
      if (sdata_out !== 32'h2) begin
         n_fail++;
         $display("FAIL rw_collision_hold: sdata_out=0x%08h expected 0x00000002", sdata_out);
      end
      bus_read(16'h0430, d);
      n_checks++;
      if (d !== 32'h55) begin
         n_fail++;
         $display("FAIL rw_collision_write: got 0x%08h expected 0x00000055", d);
      end
   endtask

   task automatic test_gpio;
      gpio_in = 32'hDEAD_BEEF;
      @(posedge clk); #1 gpio_latch = 1'b1;
      @(posedge clk); #1 gpio_latch = 1'b0;
      $display("[%0t] latch gpio_in=0x%08h", $time, gpio_in);
      n_checks++;
      if (gpio_in_s_insp !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL gpio_capture: got 0x%08h expected 0xDEADBEEF", gpio_in_s_insp);
      end
      gpio_in = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (gpio_in_s_insp !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL gpio_hold: got 0x%08h expected 0xDEADBEEF", gpio_in_s_insp);
      end
   endtask

   task automatic test_reset_mid_multiply;
      logic [31:0] d;
      bus_write(16'h0438, 32'h9);
      repeat (5) @(posedge clk);
      #1 n_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 n_reset = 1'b0;
      $display("[%0t] reset pulse during multiply", $time);
      n_checks++;
      if (gpio_out !== 32'h0 || gpio_in_s_insp !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: gpio_out=0x%08h insp=0x%08h expected 0",
                  gpio_out, gpio_in_s_insp);
      end
      repeat (30) @(posedge clk);
      #1;
      n_checks++;
      if (gpio_out !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_no_complete: gpio_out=0x%08h expected 0", gpio_out);
      end
      bus_read(16'h0450, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_status: got 0x%08h expected 0x00000000", d);
      end
      bus_read(16'h0458, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_cnt: got 0x%08h expected 0x00000000", d);
      end
   endtask

   initial begin
      n_reset    = 1'b1;
      saddress   = 16'h0;
      srd        = 1'b0;
      swr        = 1'b0;
      sdata_in   = 32'h0;
      gpio_in    = 32'h0;
      gpio_latch = 1'b0;
      test_reset();
      test_a1_access();
      test_multiply();
      test_max_and_busy();
      test_readonly_and_long_strobe();
      test_back_to_back();
      test_gpio();
      test_reset_mid_multiply();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
